// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: request struct macro,
// grant-reason enum and a safe clog2 helper.
`define REGFILE_WB_REQ_S(width_p, addr_width_lp) \
  typedef struct packed { \
    logic [addr_width_lp-1:0] addr; \
    logic [width_p-1:0]       data; \
  } wb_req_s

package regfile_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    e_grant_none,
    e_grant_pri,
    e_grant_rr,
    e_grant_starve
  } grant_reason_e;

  // clog2 that never returns 0, so single-entry ranges still get a 1-bit index
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/regfile_wb_rr_picker.sv
// Combinational round-robin first-valid search over requesters 1..num_req_p-1,
// starting at ptr_i and wrapping within that group.
module regfile_wb_rr_picker
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int num_req_p = 3,
  localparam int idx_width_lp = safe_clog2(num_req_p)
) (
  input  logic [num_req_p-1:1]    v_i,
  input  logic [idx_width_lp-1:0] ptr_i,
  output logic                    v_o,
  output logic [num_req_p-1:0]    grant_oh_o,
  output logic [idx_width_lp-1:0] idx_o
);

  localparam int num_rr_lp = num_req_p - 1;

  always_comb begin
    int base;
    int cand;
    v_o        = 1'b0;
    grant_oh_o = '0;
    idx_o      = '0;
    base       = (int'(ptr_i) >= 1 && int'(ptr_i) <= num_rr_lp) ? int'(ptr_i) : 1;
    cand       = base;
    // Scan farthest offset first so the candidate nearest the pointer wins last
    for (int off = num_rr_lp - 1; off >= 0; off--) begin
      cand = base + off;
      if (cand > num_rr_lp) cand = cand - num_rr_lp;
      if (v_i[cand]) begin
        v_o              = 1'b1;
        grant_oh_o       = '0;
        grant_oh_o[cand] = 1'b1;
        idx_o            = idx_width_lp'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: requester 0 has fixed priority, the rest are
// round-robin with a starvation guard. Optional stats/assertions: REGFILE_WB_ARBITER_STATS_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int num_req_p         = 3,
  parameter int starve_limit_p    = 8,
  parameter int x0_tied_to_zero_p = 1,
  localparam int addr_width_lp    = safe_clog2(els_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_req_p-1:0]                    req_v_i,
  input  logic [num_req_p-1:0][addr_width_lp-1:0] req_addr_i,
  input  logic [num_req_p-1:0][width_p-1:0]       req_data_i,
  output logic [num_req_p-1:0]                    req_yumi_o,
  output logic                                    w_v_o,
  output logic [addr_width_lp-1:0]                w_addr_o,
  output logic [width_p-1:0]                      w_data_o
);

  localparam int idx_width_lp = safe_clog2(num_req_p);
  localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_width_lp-1:0] starve_limit_lp = cnt_width_lp'(starve_limit_p);

  `REGFILE_WB_REQ_S(width_p, addr_width_lp);

  wb_req_s [num_req_p-1:0] req_li;
  wb_req_s                 granted;
  wb_req_s                 w_req_d, w_req_q;
  logic                    w_v_d, w_v_q;

  logic [idx_width_lp-1:0] rr_ptr_d, rr_ptr_q;
  logic [cnt_width_lp-1:0] starve_cnt_d, starve_cnt_q;

  logic                    rr_v;
  logic [num_req_p-1:0]    rr_oh;
  logic [idx_width_lp-1:0] rr_idx;
  logic [idx_width_lp-1:0] grant_idx;
  logic                    grant_any;
  logic                    grant_rr;
  grant_reason_e           reason;

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      req_li[i].addr = req_addr_i[i];
      req_li[i].data = req_data_i[i];
    end
  end

  regfile_wb_rr_picker #(
    .num_req_p(num_req_p)
  ) picker (
    .v_i       (req_v_i[num_req_p-1:1]),
    .ptr_i     (rr_ptr_q),
    .v_o       (rr_v),
    .grant_oh_o(rr_oh),
    .idx_o     (rr_idx)
  );

  // Nothing is consumed while in reset so pending requests survive it
  always_comb begin
    reason = e_grant_none;
    if (starve_cnt_q == starve_limit_lp && rr_v) reason = e_grant_starve;
    else if (req_v_i[0])                         reason = e_grant_pri;
    else if (rr_v)                               reason = e_grant_rr;
    if (reset_i) reason = e_grant_none;
  end

  assign grant_any = (reason != e_grant_none);
  assign grant_rr  = (reason == e_grant_rr) || (reason == e_grant_starve);
  assign grant_idx = grant_rr ? rr_idx : '0;
  assign granted   = req_li[grant_idx];

  always_comb begin
    req_yumi_o = '0;
    if (grant_rr)                   req_yumi_o = rr_oh;
    else if (reason == e_grant_pri) req_yumi_o = num_req_p'(1);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant_rr) begin
      starve_cnt_d = '0;
      rr_ptr_d     = (rr_idx == idx_width_lp'(num_req_p - 1)) ? idx_width_lp'(1)
                                                              : rr_idx + idx_width_lp'(1);
    end else if (reason == e_grant_pri && rr_v && starve_cnt_q != starve_limit_lp) begin
      starve_cnt_d = starve_cnt_q + cnt_width_lp'(1);
    end
  end

  // Writes to x0 are consumed and advance arbitration state but never reach the port
  always_comb begin
    w_v_d   = grant_any && !((x0_tied_to_zero_p != 0) && (granted.addr == '0));
    w_req_d = grant_any ? granted : w_req_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q     <= idx_width_lp'(1);
      starve_cnt_q <= '0;
      w_v_q        <= 1'b0;
      w_req_q      <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      w_v_q        <= w_v_d;
      w_req_q      <= w_req_d;
    end
  end

  assign w_v_o    = w_v_q;
  assign w_addr_o = w_req_q.addr;
  assign w_data_o = w_req_q.data;

`ifdef REGFILE_WB_ARBITER_STATS_EN
  logic [31:0] grant_cnt_d [num_req_p];
  logic [31:0] grant_cnt_q [num_req_p];
  logic [31:0] starve_grant_cnt_d, starve_grant_cnt_q;
  logic [31:0] x0_drop_cnt_d, x0_drop_cnt_q;

  always_comb begin
    for (int i = 0; i < num_req_p; i++)
      grant_cnt_d[i] = grant_cnt_q[i] + (req_yumi_o[i] ? 32'd1 : 32'd0);
    starve_grant_cnt_d = starve_grant_cnt_q + ((reason == e_grant_starve) ? 32'd1 : 32'd0);
    x0_drop_cnt_d      = x0_drop_cnt_q + ((grant_any && !w_v_d) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_req_p; i++) grant_cnt_q[i] <= '0;
      starve_grant_cnt_q <= '0;
      x0_drop_cnt_q      <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      starve_grant_cnt_q <= starve_grant_cnt_d;
      x0_drop_cnt_q      <= x0_drop_cnt_d;
    end
  end

  final begin
    for (int i = 0; i < num_req_p; i++)
      $display("regfile_wb_arbiter: requester %0d grants %0d", i, grant_cnt_q[i]);
    $display("regfile_wb_arbiter: starvation grants %0d, x0 drops %0d",
             starve_grant_cnt_q, x0_drop_cnt_q);
  end

  a_yumi_onehot: assert property (@(posedge clk_i) $onehot0(req_yumi_o));
  a_yumi_valid:  assert property (@(posedge clk_i) (req_yumi_o & ~req_v_i) == '0);
  for (genvar i = 0; i < num_req_p; i++) begin : g_hold
    a_req_hold: assert property (@(posedge clk_i) disable iff (reset_i)
                                 (req_v_i[i] && !req_yumi_o[i]) |=> req_v_i[i]);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic checked
// against a rule-level reference model and a write scoreboard.
module tb_regfile_wb_arbiter;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [NR-1:0]         req_v = '0;
  logic [NR-1:0][AW-1:0] req_addr = '0;
  logic [NR-1:0][W-1:0]  req_data = '0;
  logic [NR-1:0] yumi_a, yumi_b;
  logic          w_v_a, w_v_b;
  logic [AW-1:0] w_addr_a, w_addr_b;
  logic [W-1:0]  w_data_a, w_data_b;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.width_p(W), .els_p(32), .num_req_p(NR), .starve_limit_p(SL),
                       .x0_tied_to_zero_p(1)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_yumi_o(yumi_a), .w_v_o(w_v_a), .w_addr_o(w_addr_a),
    .w_data_o(w_data_a));

  regfile_wb_arbiter #(.width_p(W), .els_p(32), .num_req_p(NR), .starve_limit_p(SL),
                       .x0_tied_to_zero_p(0)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_yumi_o(yumi_b), .w_v_o(w_v_b), .w_addr_o(w_addr_b),
    .w_data_o(w_data_b));

  // Register file driven by dut_a's write port
  logic [W-1:0] rf [32];
  always @(posedge clk) if (w_v_a) rf[w_addr_a] <= w_data_a;

  // Reference model: pointer and blocked-cycle count as plain integers
  int m_ptr, m_cnt;
  logic [AW+W-1:0] exp_q[$];
  logic            exp_b_v;
  logic [AW-1:0]   exp_b_addr;
  logic [W-1:0]    exp_b_data;
  logic [NR-1:0]   exp_yumi;
  logic [NR-1:0]   obs_yumi_a, obs_yumi_b;
  logic            obs_w_v_a, obs_w_v_b;
  logic [AW-1:0]   obs_w_addr_a, obs_w_addr_b;
  logic [W-1:0]    obs_w_data_a, obs_w_data_b;

  function automatic int model_grant(input logic [NR-1:0] v);
    int rr_win = -1;
    for (int o = 0; o < NR-1; o++) begin
      int c = ((m_ptr - 1 + o) % (NR-1)) + 1;
      if (rr_win < 0 && v[c]) rr_win = c;
    end
    if (m_cnt == SL && rr_win >= 0) return rr_win;
    if (v[0]) return 0;
    return rr_win;
  endfunction

  task automatic model_update(input int g, input logic [NR-1:0] v);
    if (g >= 1) begin
      m_cnt = 0;
      m_ptr = (g == NR-1) ? 1 : g + 1;
    end else if (g == 0 && v[NR-1:1] != '0) begin
      m_cnt = (m_cnt < SL) ? m_cnt + 1 : SL;
    end
  endtask

  task automatic model_reset();
    m_ptr = 1; m_cnt = 0;
    exp_q.delete();
    exp_b_v = 1'b0; exp_b_addr = '0; exp_b_data = '0;
  endtask

  // One clock: sample yumi mid-cycle, predict, then sample the registered write port
  task automatic advance();
    int g;
    @(negedge clk);
    obs_yumi_a = yumi_a;
    obs_yumi_b = yumi_b;
    g = model_grant(req_v);
    exp_yumi = (g >= 0) ? (NR'(1) << g) : '0;
    if (g >= 0) begin
      if (req_addr[g] != '0) exp_q.push_back({req_addr[g], req_data[g]});
      exp_b_v = 1'b1; exp_b_addr = req_addr[g]; exp_b_data = req_data[g];
    end else begin
      exp_b_v = 1'b0;
    end
    model_update(g, req_v);
    @(posedge clk); #1;
    obs_w_v_a = w_v_a; obs_w_addr_a = w_addr_a; obs_w_data_a = w_data_a;
    obs_w_v_b = w_v_b; obs_w_addr_b = w_addr_b; obs_w_data_b = w_data_b;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    req_v = '0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    req_v = '1;
    for (int i = 0; i < NR; i++) begin
      req_addr[i] = AW'(i + 1);
      req_data[i] = 32'h100 + i;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      tests_run++;
      if (yumi_a !== '0 || yumi_b !== '0) begin
        fails++; $display("FAIL reset_yumi: got %b/%b expected 0", yumi_a, yumi_b);
      end
      tests_run++;
      if (w_v_a !== 1'b0 || w_v_b !== 1'b0) begin
        fails++; $display("FAIL reset_w_v: got %b/%b expected 0", w_v_a, w_v_b);
      end
    end
    @(posedge clk); #1 reset_i = 1'b0;
    model_reset();
    advance();
    tests_run++;
    if (obs_yumi_a !== 4'b0001) begin
      fails++; $display("FAIL reset_first_grant: got %b expected 0001", obs_yumi_a);
    end
    tests_run++;
    if (obs_w_v_a !== 1'b1 || obs_w_addr_a !== AW'(1)) begin
      fails++; $display("FAIL reset_first_write: got v=%b a=%0d expected v=1 a=1", obs_w_v_a, obs_w_addr_a);
    end
    req_v = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_v = 4'b0010; req_addr[1] = 5; req_data[1] = 32'hDEADBEEF;
    advance();
    req_v = '0;
    tests_run++;
    if (obs_yumi_a !== 4'b0010) begin
      fails++; $display("FAIL single_yumi: got %b expected 0010", obs_yumi_a);
    end
    tests_run++;
    if (obs_w_v_a !== 1'b1 || obs_w_addr_a !== AW'(5) || obs_w_data_a !== 32'hDEADBEEF) begin
      fails++; $display("FAIL single_write: got v=%b a=%0d d=%h expected v=1 a=5 d=deadbeef",
                        obs_w_v_a, obs_w_addr_a, obs_w_data_a);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 1; i < NR; i++) begin
      req_addr[i] = AW'(8 + i);
      req_data[i] = 32'hA0 + i;
    end
    req_v = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      advance();
      tests_run++;
      if (obs_yumi_a !== (NR'(1) << (k % 3 + 1))) begin
        fails++; $display("FAIL rr_order[%0d]: got %b expected %b", k, obs_yumi_a, NR'(1) << (k % 3 + 1));
      end
      tests_run++;
      if (obs_w_v_a !== 1'b1 || obs_w_addr_a !== AW'(8 + k % 3 + 1)) begin
        fails++; $display("FAIL rr_write[%0d]: got v=%b a=%0d expected v=1 a=%0d", k, obs_w_v_a, obs_w_addr_a, 8 + k % 3 + 1);
      end
    end
    req_v = '0;
  endtask

  task automatic test_starvation();
    int g;
    do_reset();
    req_addr[0] = 1; req_data[0] = 32'h1;
    req_addr[2] = 2; req_data[2] = 32'h2;
    req_v = 4'b0101;
    for (int k = 0; k < 18; k++) begin
      advance();
      g = (k % 9 == 8) ? 2 : 0;
      tests_run++;
      if (obs_yumi_a !== (NR'(1) << g)) begin
        fails++; $display("FAIL starve[%0d]: got %b expected %b", k, obs_yumi_a, NR'(1) << g);
      end
      tests_run++;
      if (obs_w_addr_a !== AW'(g == 0 ? 1 : 2)) begin
        fails++; $display("FAIL starve_addr[%0d]: got %0d expected %0d", k, obs_w_addr_a, g == 0 ? 1 : 2);
      end
    end
    req_v = '0;
  endtask

  task automatic test_x0();
    do_reset();
    req_v = 4'b0010; req_addr[1] = 0; req_data[1] = 32'h55;
    advance();
    tests_run++;
    if (obs_yumi_a !== 4'b0010 || obs_yumi_b !== 4'b0010) begin
      fails++; $display("FAIL x0_yumi: got %b/%b expected 0010", obs_yumi_a, obs_yumi_b);
    end
    tests_run++;
    if (obs_w_v_a !== 1'b0) begin
      fails++; $display("FAIL x0_drop: got w_v=%b expected 0", obs_w_v_a);
    end
    tests_run++;
    if (obs_w_v_b !== 1'b1 || obs_w_addr_b !== '0 || obs_w_data_b !== 32'h55) begin
      fails++; $display("FAIL x0_untied: got v=%b a=%0d d=%h expected v=1 a=0 d=55",
                        obs_w_v_b, obs_w_addr_b, obs_w_data_b);
    end
    req_v = 4'b0110; req_addr[1] = 9; req_addr[2] = 10;
    advance();
    req_v = '0;
    tests_run++;
    if (obs_yumi_a !== 4'b0100) begin
      fails++; $display("FAIL x0_ptr_advance: got %b expected 0100", obs_yumi_a);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_v = 4'b0001; req_addr[0] = 7; req_data[0] = 32'h11;
    advance();
    tests_run++;
    if (obs_yumi_a !== 4'b0001 || obs_w_v_a !== 1'b1 || obs_w_addr_a !== AW'(7) || obs_w_data_a !== 32'h11) begin
      fails++; $display("FAIL b2b_first: got y=%b v=%b a=%0d d=%h expected y=0001 v=1 a=7 d=11",
                        obs_yumi_a, obs_w_v_a, obs_w_addr_a, obs_w_data_a);
    end
    req_v = 4'b0010; req_addr[1] = 7; req_data[1] = 32'h22;
    advance();
    tests_run++;
    if (obs_yumi_a !== 4'b0010 || obs_w_v_a !== 1'b1 || obs_w_addr_a !== AW'(7) || obs_w_data_a !== 32'h22) begin
      fails++; $display("FAIL b2b_second: got y=%b v=%b a=%0d d=%h expected y=0010 v=1 a=7 d=22",
                        obs_yumi_a, obs_w_v_a, obs_w_addr_a, obs_w_data_a);
    end
    req_v = '0;
    advance();
    tests_run++;
    if (rf[7] !== 32'h22) begin
      fails++; $display("FAIL b2b_rf: got r7=%h expected 22", rf[7]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_v = 4'b0110; req_addr[1] = 3; req_data[1] = 32'h33; req_addr[2] = 4; req_data[2] = 32'h44;
    advance();
    req_v = 4'b0100;
    reset_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (yumi_a !== '0) begin
      fails++; $display("FAIL midreset_yumi: got %b expected 0", yumi_a);
    end
    @(posedge clk); #1;
    tests_run++;
    if (w_v_a !== 1'b0) begin
      fails++; $display("FAIL midreset_drop: got w_v=%b expected 0", w_v_a);
    end
    reset_i = 1'b0;
    model_reset();
    advance();
    req_v = '0;
    tests_run++;
    if (obs_yumi_a !== 4'b0100 || obs_w_v_a !== 1'b1 || obs_w_addr_a !== AW'(4)) begin
      fails++; $display("FAIL midreset_pending: got y=%b v=%b a=%0d expected y=0100 v=1 a=4",
                        obs_yumi_a, obs_w_v_a, obs_w_addr_a);
    end
  endtask

  task automatic test_random();
    logic [AW+W-1:0] e;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_v[i] && $urandom_range(0, 99) < ((i == 0) ? 85 : 40)) begin
          req_v[i]    = 1'b1;
          req_addr[i] = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
          req_data[i] = $urandom;
        end
      end
      advance();
      tests_run++;
      if (obs_yumi_a !== exp_yumi || obs_yumi_b !== exp_yumi) begin
        fails++; $display("FAIL rand_yumi[%0d]: got %b/%b expected %b", c, obs_yumi_a, obs_yumi_b, exp_yumi);
      end
      tests_run++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (obs_w_v_a !== 1'b1 || {obs_w_addr_a, obs_w_data_a} !== e) begin
          fails++; $display("FAIL rand_write_a[%0d]: got v=%b %h expected v=1 %h", c, obs_w_v_a,
                            {obs_w_addr_a, obs_w_data_a}, e);
        end
      end else if (obs_w_v_a !== 1'b0) begin
        fails++; $display("FAIL rand_idle_a[%0d]: got w_v=%b expected 0", c, obs_w_v_a);
      end
      tests_run++;
      if (obs_w_v_b !== exp_b_v || (exp_b_v && {obs_w_addr_b, obs_w_data_b} !== {exp_b_addr, exp_b_data})) begin
        fails++; $display("FAIL rand_write_b[%0d]: got v=%b %h expected v=%b %h", c, obs_w_v_b,
                          {obs_w_addr_b, obs_w_data_b}, exp_b_v, {exp_b_addr, exp_b_data});
      end
      req_v = req_v & ~exp_yumi;
    end
    req_v = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
